led_blink_engine: RTL and testbench

- Multi-channel LED indicator driver; replaces single-purpose fixed-rate flashers.
- One prescaler derives a 1 ms tick enable from CLK. No derived clocks: all logic runs on CLK and is gated by the tick.
- Each channel independently selects off, on, blink at a programmable half-period, or an 8-step pattern. Sits next to board I/O; driven by status logic or a register block.

---
 rtl/led_blink_engine_pkg.sv | 22 ++
 rtl/led_blink_channel.sv | 78 +++++++
 rtl/led_blink_engine.sv | 68 ++++++
 tb/tb_led_blink_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_engine_pkg.sv
// Shared definitions for the LED blink engine: channel mode encodings,
// pattern length and the prescaler divide-ratio helper.
package led_blink_engine_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PAT   = 2'b11
  } mode_e;

  localparam int PAT_LEN = 8;
  localparam int STEP_W  = $clog2(PAT_LEN);

  // Returns 0 when the clock is not an exact multiple of the tick rate, so the
  // instantiating module can reject the configuration at elaboration.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0 || (clk_hz % tick_hz) != 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: tick counter, blink phase, pattern step and the registered
// LED drive. All state is reset on restart or on a change of mode.
module led_blink_channel
  import led_blink_engine_pkg::*;
#(
  parameter int PER_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               sync_restart,
  input  logic [1:0]         mode,
  input  logic [PER_W-1:0]   half_period,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               led
);

  mode_e             mode_cur;
  mode_e             mode_q;
  logic [PER_W-1:0]  cnt;
  logic [PER_W-1:0]  cnt_n;
  logic [PER_W-1:0]  hp_last;
  logic              phase;
  logic              phase_n;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_n;
  logic              led_n;

  assign mode_cur = mode_e'(mode);

  always_comb begin
    cnt_n   = cnt;
    phase_n = phase;
    step_n  = step;
    led_n   = 1'b0;
    // A half-period of 0 behaves as 1; ">=" lets a shrunk period fire at once.
    hp_last = (half_period == '0) ? '0 : half_period - PER_W'(1);

    if (sync_restart || mode_cur != mode_q) begin
      cnt_n   = '0;
      phase_n = 1'b0;
      step_n  = '0;
    end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_PAT)) begin
      if (cnt >= hp_last) begin
        cnt_n = '0;
        if (mode_q == MODE_BLINK) phase_n = ~phase;
        else                      step_n  = step + STEP_W'(1);
      end else begin
        cnt_n = cnt + PER_W'(1);
      end
    end

    case (mode_cur)
      MODE_OFF:   led_n = 1'b0;
      MODE_ON:    led_n = 1'b1;
      MODE_BLINK: led_n = phase_n;
      MODE_PAT:   led_n = pattern[step_n];
      default:    led_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      cnt    <= '0;
      phase  <= 1'b0;
      step   <= '0;
      led    <= 1'b0;
    end else begin
      mode_q <= mode_cur;
      cnt    <= cnt_n;
      phase  <= phase_n;
      step   <= step_n;
      led    <= led_n;
    end
  end

endmodule

// File: rtl/led_blink_engine.sv
// Multi-channel LED indicator driver: a shared prescaler produces a one-cycle
// TICK enable at TICK_HZ, and each channel runs off/on/blink/pattern from it.
module led_blink_engine
  import led_blink_engine_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int PER_W   = 10
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    SYNC_RESTART,
  input  logic [2*N_CH-1:0]       MODE,
  input  logic [PER_W*N_CH-1:0]   HALF_PERIOD,
  input  logic [PAT_LEN*N_CH-1:0] PATTERN,
  output logic                    TICK,
  output logic [N_CH-1:0]         LED
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PRE_NEXT = CNT_W'(DIV - 2);

  if (DIV < 2) begin : g_bad_div
    $error("led_blink_engine: CLK_HZ/TICK_HZ must be an exact integer >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("led_blink_engine: N_CH must be within 1..16");
  end

  logic [CNT_W-1:0] pre_cnt;

  // TICK is raised on the edge that moves the count to DIV-1, so it is high for
  // exactly that count; a frozen prescaler never emits a tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
      TICK    <= 1'b0;
    end else if (SYNC_RESTART) begin
      pre_cnt <= '0;
      TICK    <= 1'b0;
    end else if (EN) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + CNT_W'(1);
      TICK    <= (pre_cnt == PRE_NEXT);
    end else begin
      TICK    <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_blink_channel #(
      .PER_W(PER_W)
    ) u_ch (
      .clk          (CLK),
      .rst_n        (RST_N),
      .tick         (TICK),
      .sync_restart (SYNC_RESTART),
      .mode         (MODE[2*i +: 2]),
      .half_period  (HALF_PERIOD[PER_W*i +: PER_W]),
      .pattern      (PATTERN[PAT_LEN*i +: PAT_LEN]),
      .led          (LED[i])
    );
  end

endmodule

// File: tb/tb_led_blink_engine.sv
// Scoreboard bench for led_blink_engine: stimulus pushes expected TICK/LED from
// a tick/event-count reference model; a monitor pops and compares each cycle.
module tb_led_blink_engine;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int N_CH    = 4;
  localparam int PER_W   = 4;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  EN = 1'b0;
  logic                  SYNC_RESTART = 1'b0;
  logic [2*N_CH-1:0]     MODE = '0;
  logic [PER_W*N_CH-1:0] HALF_PERIOD = '0;
  logic [8*N_CH-1:0]     PATTERN = '0;
  logic                  TICK;
  logic [N_CH-1:0]       LED;

  led_blink_engine #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N_CH), .PER_W(PER_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .SYNC_RESTART(SYNC_RESTART),
    .MODE(MODE), .HALF_PERIOD(HALF_PERIOD), .PATTERN(PATTERN),
    .TICK(TICK), .LED(LED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            tick;
    logic [N_CH-1:0] led;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // staged stimulus
  logic       s_en = 1'b1;
  logic       s_sync = 1'b0;
  logic [1:0] s_mode[N_CH];
  logic [3:0] s_hp[N_CH];
  logic [7:0] s_pat[N_CH];

  // reference model: enabled-cycle count, ticks since last event, event count
  int   m_pre;
  logic m_tick;
  int   m_ela[N_CH];
  int   m_ev[N_CH];
  logic [1:0] m_prev[N_CH];

  task automatic model_reset();
    m_pre  = 0;
    m_tick = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_ela[c]  = 0;
      m_ev[c]   = 0;
      m_prev[c] = 2'b00;
    end
  endtask

  // Called at a falling edge: applies staged inputs and predicts the next edge.
  task automatic drive_cycle();
    exp_t e;
    int   hp_eff;
    logic [N_CH-1:0] led_v;
    EN = s_en;
    SYNC_RESTART = s_sync;
    for (int c = 0; c < N_CH; c++) begin
      MODE[2*c +: 2]        = s_mode[c];
      HALF_PERIOD[4*c +: 4] = s_hp[c];
      PATTERN[8*c +: 8]     = s_pat[c];
    end
    led_v = '0;
    for (int c = 0; c < N_CH; c++) begin
      hp_eff = (s_hp[c] == 4'd0) ? 1 : int'(s_hp[c]);
      if (s_sync || s_mode[c] != m_prev[c]) begin
        m_ela[c] = 0;
        m_ev[c]  = 0;
      end else if (m_tick && (s_mode[c] == 2'b10 || s_mode[c] == 2'b11)) begin
        m_ela[c]++;
        if (m_ela[c] >= hp_eff) begin
          m_ela[c] = 0;
          m_ev[c]++;
        end
      end
      m_prev[c] = s_mode[c];
      case (s_mode[c])
        2'b00:   led_v[c] = 1'b0;
        2'b01:   led_v[c] = 1'b1;
        2'b10:   led_v[c] = logic'(m_ev[c] % 2);
        default: led_v[c] = s_pat[c][m_ev[c] % 8];
      endcase
    end
    if (s_sync) begin
      m_pre  = 0;
      m_tick = 1'b0;
    end else if (s_en) begin
      m_pre  = (m_pre + 1) % DIV;
      m_tick = (m_pre == DIV - 1);
    end else begin
      m_tick = 1'b0;
    end
    e.tick = m_tick;
    e.led  = led_v;
    e.cyc  = cyc;
    q.push_back(e);
    s_sync = 1'b0;
    cyc++;
  endtask

  task automatic step();
    @(negedge CLK);
    drive_cycle();
  endtask

  task automatic check_direct(input string name, input logic [N_CH:0] act,
                              input logic [N_CH:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_direct("async_reset_clears", {TICK, LED}, '0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drive_cycle();
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({TICK, LED} !== {e.tick, e.led}) begin
          n_errors++;
          $display("FAIL scoreboard cyc=%0d tick=%b led=%b required tick=%b led=%b",
                   e.cyc, TICK, LED, e.tick, e.led);
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      s_mode[c] = 2'b00;
      s_hp[c]   = 4'd0;
      s_pat[c]  = 8'h00;
    end
    model_reset();
    #1 check_direct("reset_state", {TICK, LED}, '0);
    repeat (2) @(negedge CLK);
    check_direct("reset_held", {TICK, LED}, '0);
    RST_N = 1'b1;
    drive_cycle();

    // all channels off: ticks every DIV cycles, LEDs dark
    repeat (40) step();

    s_mode[0] = 2'b10; s_hp[0] = 4'd3;
    s_mode[1] = 2'b11; s_hp[1] = 4'd1; s_pat[1] = 8'b1011_0001;
    s_mode[2] = 2'b10; s_hp[2] = 4'd15;
    repeat (25) step();
    s_mode[3] = 2'b10; s_hp[3] = 4'd3;
    repeat (80) step();
    s_hp[2] = 4'd4;
    repeat (150) step();

    // restart coincident with a tick
    for (int i = 0; i < 2 * DIV && !m_tick; i++) step();
    n_checks++;
    if (!m_tick) begin
      n_errors++;
      $display("FAIL sync_on_tick_setup actual=no_tick required=tick");
    end
    s_sync = 1'b1;
    step();
    repeat (120) step();

    s_hp[0] = 4'd0;
    repeat (60) step();

    s_en = 1'b0;
    repeat (25) step();
    s_en = 1'b1;
    repeat (40) step();

    async_reset();
    repeat (80) step();

    for (int n = 0; n < 2000; n++) begin
      s_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) s_sync = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 39) == 0) s_mode[c] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) s_hp[c]   = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 59) == 0) s_pat[c]  = 8'($urandom);
      end
      if ($urandom_range(0, 599) == 0) async_reset();
      else step();
    end

    repeat (3) @(negedge CLK);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
